// File: rtl/sim_exit_ctrl_if.sv
// OBI-style request/response bundle between a bus master and the simulation
// exit controller.
interface sim_exit_ctrl_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sim_exit_ctrl.sv
// Simulation exit controller: software exit register plus a cycle watchdog
// that forces a failure exit when firmware stops kicking it.
module sim_exit_ctrl #(
  parameter logic [31:0] WDT_EXIT_CODE   = 32'hDEAD_0001,
  parameter logic [31:0] WDT_RESET_LIMIT = 32'd0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sim_exit_ctrl_if.slave  bus,
  output logic            exit_valid_o,
  output logic [31:0]     exit_value_o
);

  typedef enum logic {ST_RUN, ST_EXITED} state_e;

  state_e      state_q, state_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic [31:0] wdt_limit_q, wdt_limit_d;
  logic        wdt_en_q, wdt_en_d;
  logic [31:0] cnt_q, cnt_d;
  logic        wdt_cause_q, wdt_cause_d;
  logic [31:0] exit_out_q, exit_out_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  idx;
  logic        run, wr_ok, kick, lim_wr, sw_exit, expire;
  logic        unused_addr;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign unused_addr = ^{bus.addr_i[31:5], bus.addr_i[1:0]};
  assign idx         = bus.addr_i[4:2];
  assign bus.gnt_o   = bus.req_i;

  always_comb begin
    state_d      = state_q;
    exit_value_d = exit_value_q;
    wdt_limit_d  = wdt_limit_q;
    wdt_en_d     = wdt_en_q;
    cnt_d        = cnt_q;
    wdt_cause_d  = wdt_cause_q;
    exit_out_d   = exit_out_q;
    rvalid_d     = bus.req_i;
    rdata_d      = 32'd0;

    run     = (state_q == ST_RUN);
    wr_ok   = bus.req_i && bus.we_i && run;
    kick    = wr_ok && (idx == 3'd3) && bus.be_i[0] && bus.wdata_i[1];
    lim_wr  = wr_ok && (idx == 3'd2);
    sw_exit = wr_ok && (idx == 3'd0) && bus.be_i[0] && bus.wdata_i[0];
    // A kick or limit rewrite on the expiry edge restarts the count instead.
    expire  = run && wdt_en_q && (wdt_limit_q != 32'd0) &&
              (cnt_q == wdt_limit_q - 32'd1) && !kick && !lim_wr;

    if (wr_ok) begin
      case (idx)
        3'd1: exit_value_d = be_merge(exit_value_q, bus.wdata_i, bus.be_i);
        3'd2: wdt_limit_d  = be_merge(wdt_limit_q, bus.wdata_i, bus.be_i);
        3'd3: if (bus.be_i[0]) wdt_en_d = bus.wdata_i[0];
        default: ;
      endcase
    end

    if (run) begin
      if (!wdt_en_q || kick || lim_wr) cnt_d = 32'd0;
      else                             cnt_d = cnt_q + 32'd1;
    end

    // Software exit outranks a coincident watchdog expiry.
    if (sw_exit) begin
      state_d     = ST_EXITED;
      exit_out_d  = exit_value_q;
      wdt_cause_d = 1'b0;
    end else if (expire) begin
      state_d     = ST_EXITED;
      exit_out_d  = WDT_EXIT_CODE;
      wdt_cause_d = 1'b1;
    end

    if (bus.req_i && !bus.we_i) begin
      case (idx)
        3'd1:    rdata_d = exit_value_q;
        3'd2:    rdata_d = wdt_limit_q;
        3'd3:    rdata_d = {31'd0, wdt_en_q};
        3'd4:    rdata_d = cnt_q;
        3'd5:    rdata_d = {30'd0, wdt_cause_q, (state_q == ST_EXITED)};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      exit_value_q <= 32'd0;
      wdt_limit_q  <= WDT_RESET_LIMIT;
      wdt_en_q     <= 1'b0;
      cnt_q        <= 32'd0;
      wdt_cause_q  <= 1'b0;
      exit_out_q   <= 32'd0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      exit_value_q <= exit_value_d;
      wdt_limit_q  <= wdt_limit_d;
      wdt_en_q     <= wdt_en_d;
      cnt_q        <= cnt_d;
      wdt_cause_q  <= wdt_cause_d;
      exit_out_q   <= exit_out_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign exit_valid_o  = (state_q == ST_EXITED);
  assign exit_value_o  = exit_out_q;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Bench for sim_exit_ctrl: directed scenarios plus randomized register traffic
// checked against a simple register/watchdog model.
module tb_sim_exit_ctrl;
  localparam logic [31:0] WDT_CODE = 32'hDEAD_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exit_valid;
  logic [31:0] exit_value;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sim_exit_ctrl_if bus();

  sim_exit_ctrl #(.WDT_EXIT_CODE(WDT_CODE), .WDT_RESET_LIMIT(32'd0)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus.slave),
    .exit_valid_o (exit_valid),
    .exit_value_o (exit_value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic bus_idle();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.be_i = '0; bus.wdata_i = '0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.be_i = be; bus.wdata_i = wdata;
    #1 check("gnt", {31'd0, bus.gnt_o}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
    check("rvalid", {31'd0, bus.rvalid_o}, 32'd1);
    rdata = bus.rdata_o;
    if (we) check("wr_rdata", rdata, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] d;
    xfer(1'b1, addr, be, data, d);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    xfer(1'b0, addr, 4'hF, 32'd0, data);
  endtask

  // Exit write with a check that the flag was low just before the grant edge.
  task automatic sw_exit();
    @(negedge clk);
    check("pre_exit_valid", {31'd0, exit_valid}, 32'd0);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0; bus.be_i = 4'h1; bus.wdata_i = 32'h1;
    @(posedge clk); #1;
    bus_idle();
    check("exit_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
    check("exit_valid_lat1", {31'd0, exit_valid}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, ev, lim, wd, hit;
    logic [3:0]  be;
    logic        we;
    int          sel[6] = '{0, 1, 2, 5, 6, 7};
    int          idx, n;

    bus_idle();
    #2;
    check("rst_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
    check("rst_rdata", bus.rdata_o, 32'd0);
    check("rst_exit_valid", {31'd0, exit_valid}, 32'd0);
    check("rst_exit_value", exit_value, 32'd0);
    check("rst_gnt", {31'd0, bus.gnt_o}, 32'd0);
    do_reset();

    // Idle: nothing may respond or exit.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("idle_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
      check("idle_exit_valid", {31'd0, exit_valid}, 32'd0);
    end
    rd(32'h08, d); check("rst_wdt_limit", d, 32'd0);

    // Simple software exit with value 0.
    wr(32'h04, 32'h0, 4'hF);
    sw_exit();
    check("exit0_value", exit_value, 32'd0);
    rd(32'h14, d); check("exit0_status", d, 32'h1);

    // Byte-masked exit value.
    do_reset();
    wr(32'h04, 32'h1234_5678, 4'b0011);
    sw_exit();
    check("mask_exit_value", exit_value, 32'h0000_5678);

    // Randomized register traffic against the model, then exit with the model value.
    do_reset();
    ev = 32'd0; lim = 32'd0;
    for (int t = 0; t < 40; t++) begin
      idx = sel[$urandom_range(0, 5)];
      we  = 1'($urandom_range(0, 1));
      be  = 4'($urandom);
      wd  = $urandom;
      if (idx == 0) wd[0] = 1'b0;
      xfer(we, 32'(idx * 4), be, wd, d);
      if (we) begin
        if (idx == 1) ev  = merge(ev, wd, be);
        if (idx == 2) lim = merge(lim, wd, be);
      end else begin
        case (idx)
          1:       check("rand_rd_exit_value", d, ev);
          2:       check("rand_rd_wdt_limit", d, lim);
          default: check("rand_rd_zero", d, 32'd0);
        endcase
      end
    end
    check("rand_no_exit", {31'd0, exit_valid}, 32'd0);
    sw_exit();
    check("rand_exit_value", exit_value, ev);

    // Watchdog expiry: limit 100 and a random limit.
    for (int r = 0; r < 2; r++) begin
      lim = (r == 0) ? 32'd100 : 32'($urandom_range(3, 60));
      do_reset();
      wr(32'h08, lim, 4'hF);
      wr(32'h0C, 32'h1, 4'h1);
      hit = 32'd0;
      for (int k = 1; k <= 200; k++) begin
        @(posedge clk); #1;
        if (exit_valid) begin hit = 32'(k); break; end
      end
      check("wdt_expiry_cycle", hit, lim);
      check("wdt_exit_value", exit_value, WDT_CODE);
      rd(32'h14, d); check("wdt_status", d, 32'h3);
    end

    // Kicked every 50 cycles: no exit over 1000 cycles.
    do_reset();
    wr(32'h08, 32'd100, 4'hF);
    wr(32'h0C, 32'h1, 4'h1);
    for (int p = 0; p < 20; p++) begin
      wr(32'h0C, 32'h3, 4'h1);
      repeat (49) @(posedge clk);
    end
    check("kick_no_exit", {31'd0, exit_valid}, 32'd0);
    wr(32'h0C, 32'h3, 4'h1);
    n = $urandom_range(5, 40);
    repeat (n) @(posedge clk);
    rd(32'h10, d); check("kick_cycle_cnt", d, 32'(n));
    rd(32'h14, d); check("kick_status", d, 32'h0);

    // Frozen after exit, then asynchronous reset clears the flag at once.
    do_reset();
    wr(32'h04, 32'd7, 4'hF);
    sw_exit();
    wr(32'h04, 32'd9, 4'hF);
    wr(32'h00, 32'd1, 4'h1);
    check("frozen_exit_value", exit_value, 32'd7);
    rd(32'h04, d); check("frozen_rd_exit_value", d, 32'd7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_exit_valid", {31'd0, exit_valid}, 32'd0);
    check("async_rst_exit_value", exit_value, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Software exit on the watchdog expiry edge wins.
    do_reset();
    wr(32'h04, 32'd3, 4'hF);
    wr(32'h08, 32'd10, 4'hF);
    wr(32'h0C, 32'h1, 4'h1);
    repeat (9) @(posedge clk);
    sw_exit();
    check("race_exit_value", exit_value, 32'd3);
    rd(32'h14, d); check("race_status", d, 32'h1);

    // Back-to-back accesses to an unmapped offset.
    rd(32'h1C, d); check("unmapped_rd0", d, 32'd0);
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
    rd(32'h1C, d); check("unmapped_rd1", d, 32'd0);
    @(posedge clk); #1;
    check("rvalid_drops", {31'd0, bus.rvalid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
